dc_port_arbiter: RTL and testbench

Arbiter and sequencer for the single dcache read port, which is shared by three requesters: the memory1 page-table walker (ptw), fetch1 refill/walk reads (fe), and pipeline load/store accesses (ls). It owns the dcache request signals and holds each request stable until the dcache accepts it. Arbitration is fixed-priority with an anti-starvation override for ls. It also drives translation and ASID from `csr_satp`, and honours `csr_kill` for pipeline accesses. It sits between memory0/memory1/fetch1 and the dcache.

---
 rtl/dc_port_arbiter_if.sv | 68 ++++++
 rtl/dc_port_arbiter.sv | 136 +++++++++++++
 tb/tb_dc_port_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dc_port_arbiter_if.sv
// Bundle between the dcache read-port arbiter and its requesters/dcache.
// slave: arbiter side; master: requesters, csr and dcache side.
interface dc_port_arbiter_if;
  logic        ptw_req;
  logic        ptw_trans;
  logic [29:0] ptw_addr;
  logic        ptw_gnt;

  logic        fe_req;
  logic [26:0] fe_addr;
  logic        fe_gnt;

  logic        ls_req;
  logic [29:0] ls_addr;
  logic        ls_gnt;

  logic        csr_kill;
  logic [31:0] csr_satp;

  logic        dc_read;
  logic        dc_trans;
  logic [8:0]  dc_asid;
  logic [29:0] dc_addr;
  logic        dc_ready;
  logic [1:0]  arb_owner;

  modport slave (
    input  ptw_req,
    input  ptw_trans,
    input  ptw_addr,
    output ptw_gnt,
    input  fe_req,
    input  fe_addr,
    output fe_gnt,
    input  ls_req,
    input  ls_addr,
    output ls_gnt,
    input  csr_kill,
    input  csr_satp,
    output dc_read,
    output dc_trans,
    output dc_asid,
    output dc_addr,
    input  dc_ready,
    output arb_owner
  );

  modport master (
    output ptw_req,
    output ptw_trans,
    output ptw_addr,
    input  ptw_gnt,
    output fe_req,
    output fe_addr,
    input  fe_gnt,
    output ls_req,
    output ls_addr,
    input  ls_gnt,
    output csr_kill,
    output csr_satp,
    input  dc_read,
    input  dc_trans,
    input  dc_asid,
    input  dc_addr,
    output dc_ready,
    input  arb_owner
  );
endinterface

// File: rtl/dc_port_arbiter.sv
// dcache read-port arbiter: ptw > fe > ls, ls anti-starvation, csr_kill.
// Ports: clk_core, reset_n (async, low), bus (dc_port_arbiter_if.slave).
module dc_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic              clk_core,
  input logic              reset_n,
  dc_port_arbiter_if.slave bus
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_PTW  = 2'b01;
  localparam logic [1:0] OWN_FE   = 2'b10;
  localparam logic [1:0] OWN_LS   = 2'b11;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [0:0]  state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [29:0] addr_q, addr_d;
  logic        trans_q, trans_d;
  logic [3:0]  starve_q, starve_d;

  logic issue;
  logic accept;
  logic ls_kill;
  logic arb_en;
  logic ptw_g, fe_g, ls_g;
  logic ptw_c, fe_c, ls_c;
  logic starved;
  logic win_ptw, win_fe, win_ls;
  logic unused_satp;

  assign issue   = (state_q == S_ISSUE);
  assign accept  = issue & bus.dc_ready;
  assign ls_kill = issue & (owner_q == OWN_LS) & bus.csr_kill;

  assign ptw_g = accept & (owner_q == OWN_PTW);
  assign fe_g  = accept & (owner_q == OWN_FE);
  assign ls_g  = accept & (owner_q == OWN_LS)
               & ~bus.csr_kill;

  // A killed ls access is abandoned, so the port is free to re-arbitrate
  // even if the dcache has not accepted it.
  assign arb_en = ~issue | bus.dc_ready | ls_kill;

  // The requester granted this cycle is not a candidate again.
  assign ptw_c = bus.ptw_req & ~ptw_g;
  assign fe_c  = bus.fe_req & ~fe_g;
  assign ls_c  = bus.ls_req & ~bus.csr_kill & ~ls_g;

  assign starved = (starve_q >= LIMIT);

  assign win_ptw = ptw_c;
  assign win_ls  = ~ptw_c & ls_c & (starved | ~fe_c);
  assign win_fe  = ~ptw_c & fe_c & ~(ls_c & starved);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    trans_d = trans_q;
    if (arb_en) begin
      unique case (1'b1)
        win_ptw: begin
          state_d = S_ISSUE;
          owner_d = OWN_PTW;
          addr_d  = bus.ptw_addr;
          trans_d = bus.ptw_trans;
        end
        win_fe: begin
          state_d = S_ISSUE;
          owner_d = OWN_FE;
          addr_d  = {3'b000, bus.fe_addr};
          trans_d = 1'b0;
        end
        win_ls: begin
          state_d = S_ISSUE;
          owner_d = OWN_LS;
          addr_d  = bus.ls_addr;
          trans_d = bus.csr_satp[31];
        end
        default: begin
          state_d = S_IDLE;
          owner_d = OWN_NONE;
        end
      endcase
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (arb_en) begin
      if (ls_kill) begin
        starve_d = 4'd0;
      end else if (win_fe & ls_c) begin
        if (starve_q != 4'hf) begin
          starve_d = starve_q + 4'd1;
        end
      end else if (win_ls | ~bus.ls_req) begin
        starve_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_NONE;
      addr_q   <= '0;
      trans_q  <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      trans_q  <= trans_d;
      starve_q <= starve_d;
    end
  end

  assign bus.ptw_gnt   = ptw_g;
  assign bus.fe_gnt    = fe_g;
  assign bus.ls_gnt    = ls_g;
  assign bus.dc_read   = issue;
  assign bus.dc_trans  = trans_q;
  assign bus.dc_addr   = addr_q;
  assign bus.arb_owner = owner_q;
  assign bus.dc_asid   = bus.csr_satp[30:22];

  assign unused_satp = ^bus.csr_satp[21:0];

endmodule

// File: tb/tb_dc_port_arbiter.sv
// Self-checking bench for dc_port_arbiter: reference model plus
// directed scenarios with literal expectations.
module tb_dc_port_arbiter;
  localparam int LIMIT = 4;

  logic clk_core = 1'b0;
  logic reset_n  = 1'b0;
  always #5 clk_core = ~clk_core;

  dc_port_arbiter_if bus();

  dc_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_core(clk_core),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  // model state: outputs as they must appear after the latest edge
  bit          m_busy;
  int          m_owner;
  logic [29:0] m_addr;
  logic        m_trans;
  int          m_starve;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_s(string name, string act, string exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %s want %s", name, act, exp);
    end
  endtask

  function automatic int cur_gnt();
    if (m_busy && bus.dc_ready && !(m_owner == 3 && bus.csr_kill))
      return m_owner;
    return 0;
  endfunction

  task automatic model_reset();
    m_busy   = 1'b0;
    m_owner  = 0;
    m_addr   = '0;
    m_trans  = 1'b0;
    m_starve = 0;
  endtask

  task automatic compare();
    int g;
    g = cur_gnt();
    chk("dc_read",   32'(bus.dc_read),   32'(m_busy));
    chk("arb_owner", 32'(bus.arb_owner), 32'(m_owner));
    chk("dc_addr",   32'(bus.dc_addr),   32'(m_addr));
    chk("dc_trans",  32'(bus.dc_trans),  32'(m_trans));
    chk("dc_asid",   32'(bus.dc_asid),   32'(bus.csr_satp >> 22) & 32'h1ff);
    chk("ptw_gnt",   32'(bus.ptw_gnt),   32'(g == 1));
    chk("fe_gnt",    32'(bus.fe_gnt),    32'(g == 2));
    chk("ls_gnt",    32'(bus.ls_gnt),    32'(g == 3));
  endtask

  // one clock edge of the port rules, evaluated from current inputs
  task automatic model_step();
    int  g;
    bit  abort;
    bit  pc, fc, lc;
    int  win;
    int  order[3];
    g     = cur_gnt();
    abort = m_busy && m_owner == 3 && bus.csr_kill;
    if (m_busy && !bus.dc_ready && !abort) return;
    pc = bus.ptw_req && g != 1;
    fc = bus.fe_req && g != 2;
    lc = bus.ls_req && !bus.csr_kill && g != 3;
    order[0] = 1;
    if (m_starve >= LIMIT) begin
      order[1] = 3; order[2] = 2;
    end else begin
      order[1] = 2; order[2] = 3;
    end
    win = 0;
    for (int i = 0; i < 3; i++) begin
      if (win == 0 && ((order[i] == 1 && pc) ||
                       (order[i] == 2 && fc) ||
                       (order[i] == 3 && lc)))
        win = order[i];
    end
    if (abort) m_starve = 0;
    else if (win == 2 && lc) m_starve = (m_starve < 15) ? m_starve + 1 : 15;
    else if (win == 3 || !bus.ls_req) m_starve = 0;
    case (win)
      1: begin
        m_busy = 1'b1; m_owner = 1;
        m_addr = bus.ptw_addr; m_trans = bus.ptw_trans;
      end
      2: begin
        m_busy = 1'b1; m_owner = 2;
        m_addr = {3'b000, bus.fe_addr}; m_trans = 1'b0;
      end
      3: begin
        m_busy = 1'b1; m_owner = 3;
        m_addr = bus.ls_addr; m_trans = bus.csr_satp[31];
      end
      default: begin
        m_busy = 1'b0; m_owner = 0;
      end
    endcase
  endtask

  task automatic look();
    @(negedge clk_core);
    compare();
  endtask

  task automatic go();
    if (reset_n) model_step();
    @(posedge clk_core);
    #1;
  endtask

  task automatic cyc();
    look();
    go();
  endtask

  function automatic string gch();
    if (bus.ptw_gnt) return "P";
    if (bus.fe_gnt)  return "F";
    if (bus.ls_gnt)  return "L";
    return "-";
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string seq;
    string c;
    bus.ptw_req = 0; bus.ptw_trans = 0; bus.ptw_addr = '0;
    bus.fe_req = 0; bus.fe_addr = '0;
    bus.ls_req = 0; bus.ls_addr = '0;
    bus.csr_kill = 0; bus.csr_satp = '0; bus.dc_ready = 0;
    model_reset();
    repeat (2) @(posedge clk_core);
    #1 reset_n = 1'b1;

    // reset state
    look();
    chk("rst_read",  32'(bus.dc_read),   32'd0);
    chk("rst_owner", 32'(bus.arb_owner), 32'd0);
    chk("rst_addr",  32'(bus.dc_addr),   32'd0);
    go();

    // single ls access
    bus.csr_satp = 32'h8040_0000;
    bus.ls_addr  = 30'h0400_0001;
    bus.dc_ready = 1;
    bus.ls_req   = 1;
    cyc();
    look();
    chk("ls1_read",  32'(bus.dc_read),   32'd1);
    chk("ls1_trans", 32'(bus.dc_trans),  32'd1);
    chk("ls1_asid",  32'(bus.dc_asid),   32'd1);
    chk("ls1_addr",  32'(bus.dc_addr),   32'h0400_0001);
    chk("ls1_owner", 32'(bus.arb_owner), 32'd3);
    chk("ls1_gnt",   32'(bus.ls_gnt),    32'd1);
    go();
    bus.ls_req = 0;
    look();
    chk("ls1_idle", 32'(bus.dc_read), 32'd0);
    go();

    // simultaneous requests
    bus.ptw_addr = 30'h0000_0100; bus.ptw_trans = 1;
    bus.fe_addr  = 27'h7ff_ffff;
    bus.ls_addr  = 30'h3fff_ffff;
    bus.csr_satp = 32'h8000_0000;
    bus.ptw_req = 1; bus.fe_req = 1; bus.ls_req = 1;
    seq = "";
    for (int k = 0; k < 5; k++) begin
      look();
      c = gch();
      seq = {seq, c};
      if (c == "F") begin
        chk("sim_fe_hi",    32'(bus.dc_addr[29:27]), 32'd0);
        chk("sim_fe_trans", 32'(bus.dc_trans),       32'd0);
      end
      go();
      if (c == "P") bus.ptw_req = 0;
      if (c == "F") bus.fe_req = 0;
      if (c == "L") bus.ls_req = 0;
    end
    chk_s("sim_order", seq, "-PFL-");

    // starvation: ptw and fe keep requesting, ls held until served
    bus.ptw_req = 1; bus.fe_req = 1; bus.ls_req = 1;
    bus.fe_addr = 27'h000_0040;
    seq = "";
    for (int k = 0; k < 13; k++) begin
      look();
      c = gch();
      seq = {seq, c};
      go();
      if (c == "L") bus.ls_req = 0;
    end
    chk_s("starve_order", seq, "-PFPFPFPFPLPF");
    bus.ptw_req = 0; bus.fe_req = 0; bus.ls_req = 0;
    repeat (3) cyc();

    // kill during a stalled ls access
    bus.dc_ready = 0;
    bus.ls_addr  = 30'h0000_0abc;
    bus.ls_req   = 1;
    cyc();
    for (int k = 0; k < 3; k++) begin
      look();
      chk("kill_stall_owner", 32'(bus.arb_owner), 32'd3);
      go();
    end
    bus.csr_kill = 1; bus.dc_ready = 1;
    bus.fe_req = 1; bus.fe_addr = 27'h000_0123;
    look();
    chk("kill_ls_gnt", 32'(bus.ls_gnt), 32'd0);
    go();
    bus.csr_kill = 0; bus.ls_req = 0;
    look();
    chk("kill_owner", 32'(bus.arb_owner), 32'd2);
    chk("kill_addr",  32'(bus.dc_addr),   32'h0000_0123);
    go();
    bus.fe_req = 0;
    repeat (2) cyc();

    // long stall on fe with ptw arriving mid-stall
    bus.dc_ready = 0;
    bus.fe_addr  = 27'h2ab_cdef;
    bus.fe_req   = 1;
    cyc();
    for (int k = 1; k <= 10; k++) begin
      if (k == 3) begin
        bus.ptw_req = 1; bus.ptw_addr = 30'h2000_0040; bus.ptw_trans = 0;
      end
      look();
      chk("stall_owner", 32'(bus.arb_owner), 32'd2);
      chk("stall_addr",  32'(bus.dc_addr),   32'h02ab_cdef);
      go();
    end
    bus.dc_ready = 1;
    look();
    chk("stall_fe_gnt",  32'(bus.fe_gnt),  32'd1);
    chk("stall_ptw_gnt", 32'(bus.ptw_gnt), 32'd0);
    go();
    bus.fe_req = 0;
    look();
    chk("stall_ptw_owner", 32'(bus.arb_owner), 32'd1);
    chk("stall_ptw_addr",  32'(bus.dc_addr),   32'h2000_0040);
    go();
    bus.ptw_req = 0;
    repeat (2) cyc();

    // asid follows satp without a clock
    bus.csr_satp = 32'h7fc0_0000;
    #1 chk("asid_comb", 32'(bus.dc_asid), 32'h1ff);
    cyc();

    // asynchronous reset while an fe access is issued
    bus.dc_ready = 0;
    bus.fe_addr  = 27'h000_0777;
    bus.fe_req   = 1;
    cyc();
    look();
    chk("pre_rst_read", 32'(bus.dc_read), 32'd1);
    go();
    bus.dc_ready = 1;
    #1 reset_n = 1'b0;
    #1;
    chk("arst_read",  32'(bus.dc_read),   32'd0);
    chk("arst_owner", 32'(bus.arb_owner), 32'd0);
    chk("arst_fegnt", 32'(bus.fe_gnt),    32'd0);
    chk("arst_addr",  32'(bus.dc_addr),   32'd0);
    model_reset();
    bus.fe_req = 0;
    #1 reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      look();
      chk("post_rst_quiet", 32'(bus.dc_read), 32'd0);
      go();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
